// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_pkg
// Description : Shared defaults and limits for the clock-divider bank.
// Revision    : 1.0 - initial release
// ============================================================================
package clk_div_pkg;

  // Default channel count, divisor width and post-reset divisor
  localparam int DEF_NUM_CH  = 4;
  localparam int DEF_DIV_W   = 8;
  localparam int DEF_RST_DIV = 2;

  // Largest channel count the bank elaborates
  localparam int MAX_CH      = 16;

endpackage : clk_div_pkg
`default_nettype wire

// File: rtl/clk_div_chan.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_chan
// Description : One divider channel. Holds an active divisor, a pending
//               divisor and a period counter; produces a registered square
//               wave and a registered period-start tick. A pending divisor is
//               only adopted at a period boundary (wrap, sync or start) so no
//               period is ever truncated or stretched.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int DIV_W   = DEF_DIV_W,
  parameter int RST_DIV = DEF_RST_DIV
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             load_i,
  input  logic             sync_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             wave_o,
  output logic             tick_o,
  output logic             pend_o
);

  logic [DIV_W-1:0] div_q, div_d;   // active divisor N
  logic [DIV_W-1:0] pdiv_q, pdiv_d; // pending divisor P
  logic             pend_q, pend_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;   // channel was counting in the current cycle
  logic             wave_q, wave_d;
  logic             tick_q, tick_d;

  logic             sync_w;
  logic             wrap_w;
  logic             apply_pend_w;
  logic             apply_load_w;
  logic [DIV_W-1:0] half_w;

  // Next-state decode: divisor hand-over, counter stepping and output flops
  always_comb begin
    sync_w       = sync_i && en_i;
    wrap_w       = run_q && (cnt_q == (div_q - DIV_W'(1)));
    // A load coinciding with sync is taken straight into the active divisor
    apply_load_w = load_i && sync_w;
    // Pending value is adopted at a boundary, or at once when not counting
    apply_pend_w = pend_q && (sync_w || wrap_w || !run_q || !en_i);

    div_d = div_q;
    if (apply_load_w) begin
      div_d = div_i;
    end else if (apply_pend_w) begin
      div_d = pdiv_q;
    end

    pdiv_d = load_i ? div_i : pdiv_q;

    pend_d = pend_q;
    if (load_i) begin
      pend_d = !apply_load_w;
    end else if (apply_pend_w) begin
      pend_d = 1'b0;
    end

    run_d = en_i && (div_d != '0);

    cnt_d = '0;
    if (run_d && run_q && !sync_w && !wrap_w) begin
      cnt_d = cnt_q + DIV_W'(1);
    end

    // ceil(N/2) cannot overflow DIV_W bits
    half_w = (div_d >> 1) + {{(DIV_W-1){1'b0}}, div_d[0]};
    wave_d = run_d && (cnt_d < half_w);
    tick_d = run_d && (cnt_d == '0);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q  <= DIV_W'(RST_DIV);
      pdiv_q <= DIV_W'(RST_DIV);
      pend_q <= 1'b0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      wave_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      pdiv_q <= pdiv_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      wave_q <= wave_d;
      tick_q <= tick_d;
    end
  end

  assign wave_o = wave_q;
  assign tick_o = tick_q;
  assign pend_o = pend_q;

endmodule : clk_div_chan
`default_nettype wire

// File: rtl/clk_div_bank.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_bank
// Description : Bank of NUM_CH independent programmable clock dividers.
//               Slices the packed divisor bus per channel and fans the shared
//               sync pulse out to every channel.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int NUM_CH  = DEF_NUM_CH,
  parameter int DIV_W   = DEF_DIV_W,
  parameter int RST_DIV = DEF_RST_DIV
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       en_i,
  input  logic [NUM_CH*DIV_W-1:0] div_i,
  input  logic [NUM_CH-1:0]       load_i,
  input  logic                    sync_i,
  output logic [NUM_CH-1:0]       wave_o,
  output logic [NUM_CH-1:0]       tick_o,
  output logic [NUM_CH-1:0]       pend_o
);

  // One channel per slot, bounded by the largest supported bank size
  for (genvar k = 0; k < MAX_CH; k++) begin : g_chan
    if (k < NUM_CH) begin : g_inst
      clk_div_chan #(
        .DIV_W   (DIV_W),
        .RST_DIV (RST_DIV)
      ) u_chan (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (en_i[k]),
        .load_i (load_i[k]),
        .sync_i (sync_i),
        .div_i  (div_i[k*DIV_W +: DIV_W]),
        .wave_o (wave_o[k]),
        .tick_o (tick_o[k]),
        .pend_o (pend_o[k])
      );
    end
  end

endmodule : clk_div_bank
`default_nettype wire

// File: tb/tb_clk_div_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_div_bank
// Description : Directed scoreboard bench for clk_div_bank (4 ch, 8-bit div).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_div_bank;

  logic        clk;
  logic        rst_n;
  logic [3:0]  en_i;
  logic [31:0] div_i;
  logic [3:0]  load_i;
  logic        sync_i;
  logic [3:0]  wave_o;
  logic [3:0]  tick_o;
  logic [3:0]  pend_o;

  typedef struct {
    logic [3:0] w;
    logic [3:0] t;
    logic [3:0] p;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  clk_div_bank #(
    .NUM_CH  (4),
    .DIV_W   (8),
    .RST_DIV (2)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (en_i),
    .div_i  (div_i),
    .load_i (load_i),
    .sync_i (sync_i),
    .wave_o (wave_o),
    .tick_o (tick_o),
    .pend_o (pend_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs and queue the outputs expected after the edge
  task automatic step(input logic [3:0] en, input logic [3:0] ld, input logic sy,
                      input logic rn, input logic [31:0] dv,
                      input logic [3:0] ew, input logic [3:0] et,
                      input logic [3:0] ep, input string nm);
    exp_t e;
    @(negedge clk);
    en_i   = en;
    load_i = ld;
    sync_i = sy;
    rst_n  = rn;
    div_i  = dv;
    e.w = ew; e.t = et; e.p = ep; e.name = nm;
    sb.push_back(e);
  endtask

  // Monitor: compare every presented output cycle against the queue head
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if ({wave_o, tick_o, pend_o} !== {e.w, e.t, e.p}) begin
        errors++;
        $display("FAIL %s: wave/tick/pend got %b/%b/%b expected %b/%b/%b",
                 e.name, wave_o, tick_o, pend_o, e.w, e.t, e.p);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; en_i = '0; load_i = '0; sync_i = 1'b0; div_i = '0;

    // Reset state
    step(4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0, 4'b0000, 4'b0000, 4'b0000, "reset0");
    step(4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0, 4'b0000, 4'b0000, 4'b0000, "reset1");

    // ch0 with reset divisor 2
    step(4'b0001, 4'b0000, 1'b0, 1'b1, 32'h0, 4'b0001, 4'b0001, 4'b0000, "A_n2_c0");
    step(4'b0001, 4'b0000, 1'b0, 1'b1, 32'h0, 4'b0000, 4'b0000, 4'b0000, "A_n2_c1");
    step(4'b0001, 4'b0000, 1'b0, 1'b1, 32'h0, 4'b0001, 4'b0001, 4'b0000, "A_n2_c0b");
    step(4'b0001, 4'b0000, 1'b0, 1'b1, 32'h0, 4'b0000, 4'b0000, 4'b0000, "A_n2_c1b");
    step(4'b0000, 4'b0000, 1'b0, 1'b1, 32'h0, 4'b0000, 4'b0000, 4'b0000, "A_off");

    // ch1 N=3: 1,1,0 duty
    step(4'b0000, 4'b0010, 1'b0, 1'b1, 32'h0000_0300, 4'b0000, 4'b0000, 4'b0010, "B_load");
    step(4'b0000, 4'b0000, 1'b0, 1'b1, 32'h0, 4'b0000, 4'b0000, 4'b0000, "B_apply");
    for (int i = 0; i < 6; i++)
      step(4'b0010, 4'b0000, 1'b0, 1'b1, 32'h0,
           ((i % 3) < 2) ? 4'b0010 : 4'b0000, ((i % 3) == 0) ? 4'b0010 : 4'b0000,
           4'b0000, "B_n3");
    step(4'b0000, 4'b0000, 1'b0, 1'b1, 32'h0, 4'b0000, 4'b0000, 4'b0000, "B_off");

    // ch2 N=16: 8 high / 8 low, tick every 16
    step(4'b0000, 4'b0100, 1'b0, 1'b1, 32'h0010_0000, 4'b0000, 4'b0000, 4'b0100, "N16_load");
    step(4'b0000, 4'b0000, 1'b0, 1'b1, 32'h0, 4'b0000, 4'b0000, 4'b0000, "N16_apply");
    for (int i = 0; i < 32; i++)
      step(4'b0100, 4'b0000, 1'b0, 1'b1, 32'h0,
           ((i % 16) < 8) ? 4'b0100 : 4'b0000, ((i % 16) == 0) ? 4'b0100 : 4'b0000,
           4'b0000, "N16_run");
    step(4'b0000, 4'b0000, 1'b0, 1'b1, 32'h0, 4'b0000, 4'b0000, 4'b0000, "N16_off");

    // ch0 N=4, loads mid-period (9 then 6, last wins), applied at wrap
    step(4'b0000, 4'b0001, 1'b0, 1'b1, 32'h04, 4'b0000, 4'b0000, 4'b0001, "C_load4");
    step(4'b0000, 4'b0000, 1'b0, 1'b1, 32'h0, 4'b0000, 4'b0000, 4'b0000, "C_apply4");
    step(4'b0001, 4'b0000, 1'b0, 1'b1, 32'h0, 4'b0001, 4'b0001, 4'b0000, "C_cnt0");
    step(4'b0001, 4'b0001, 1'b0, 1'b1, 32'h09, 4'b0001, 4'b0000, 4'b0001, "C_load9");
    step(4'b0001, 4'b0001, 1'b0, 1'b1, 32'h06, 4'b0000, 4'b0000, 4'b0001, "C_load6");
    step(4'b0001, 4'b0000, 1'b0, 1'b1, 32'h0, 4'b0000, 4'b0000, 4'b0001, "C_cnt3");
    step(4'b0001, 4'b0000, 1'b0, 1'b1, 32'h0, 4'b0001, 4'b0001, 4'b0000, "C_wrap6");
    for (int i = 1; i <= 6; i++)
      step(4'b0001, 4'b0000, 1'b0, 1'b1, 32'h0,
           ((i % 6) < 3) ? 4'b0001 : 4'b0000, ((i % 6) == 0) ? 4'b0001 : 4'b0000,
           4'b0000, "C_n6");
    step(4'b0000, 4'b0000, 1'b0, 1'b1, 32'h0, 4'b0000, 4'b0000, 4'b0000, "C_off");

    // ch0 N=4, ch1 N=6 out of phase, then sync
    step(4'b0000, 4'b0011, 1'b0, 1'b1, 32'h0000_0604, 4'b0000, 4'b0000, 4'b0011, "D_load");
    step(4'b0000, 4'b0000, 1'b0, 1'b1, 32'h0, 4'b0000, 4'b0000, 4'b0000, "D_apply");
    step(4'b0001, 4'b0000, 1'b0, 1'b1, 32'h0, 4'b0001, 4'b0001, 4'b0000, "D_a0");
    step(4'b0001, 4'b0000, 1'b0, 1'b1, 32'h0, 4'b0001, 4'b0000, 4'b0000, "D_a1");
    step(4'b0011, 4'b0000, 1'b0, 1'b1, 32'h0, 4'b0010, 4'b0010, 4'b0000, "D_b0");
    step(4'b0011, 4'b0000, 1'b0, 1'b1, 32'h0, 4'b0010, 4'b0000, 4'b0000, "D_b1");
    step(4'b0011, 4'b0000, 1'b1, 1'b1, 32'h0, 4'b0011, 4'b0011, 4'b0000, "D_sync");
    for (int j = 1; j <= 12; j++)
      step(4'b0011, 4'b0000, 1'b0, 1'b1, 32'h0,
           {2'b00, ((j % 6) < 3), ((j % 4) < 2)},
           {2'b00, ((j % 6) == 0), ((j % 4) == 0)},
           4'b0000, "D_insync");
    // load coinciding with sync is applied by the sync
    step(4'b0011, 4'b0001, 1'b1, 1'b1, 32'h02, 4'b0011, 4'b0011, 4'b0000, "D_ldsync");
    step(4'b0011, 4'b0000, 1'b0, 1'b1, 32'h0, 4'b0010, 4'b0000, 4'b0000, "D_ls1");
    step(4'b0011, 4'b0000, 1'b0, 1'b1, 32'h0, 4'b0011, 4'b0001, 4'b0000, "D_ls2");
    step(4'b0000, 4'b0000, 1'b0, 1'b1, 32'h0, 4'b0000, 4'b0000, 4'b0000, "D_off");

    // ch3 N=0 stays stopped, then N=1 is constant high
    step(4'b0000, 4'b1000, 1'b0, 1'b1, 32'h0, 4'b0000, 4'b0000, 4'b1000, "E_load0");
    step(4'b0000, 4'b0000, 1'b0, 1'b1, 32'h0, 4'b0000, 4'b0000, 4'b0000, "E_apply0");
    step(4'b1000, 4'b0000, 1'b0, 1'b1, 32'h0, 4'b0000, 4'b0000, 4'b0000, "E_n0a");
    step(4'b1000, 4'b0000, 1'b0, 1'b1, 32'h0, 4'b0000, 4'b0000, 4'b0000, "E_n0b");
    step(4'b1000, 4'b1000, 1'b0, 1'b1, 32'h0100_0000, 4'b0000, 4'b0000, 4'b1000, "E_load1");
    for (int i = 0; i < 3; i++)
      step(4'b1000, 4'b0000, 1'b0, 1'b1, 32'h0, 4'b1000, 4'b1000, 4'b0000, "E_n1");
    step(4'b0000, 4'b0000, 1'b0, 1'b1, 32'h0, 4'b0000, 4'b0000, 4'b0000, "E_off");

    // ch0 N=5 interrupted by reset, comes back with divisor 2
    step(4'b0000, 4'b0001, 1'b0, 1'b1, 32'h05, 4'b0000, 4'b0000, 4'b0001, "F_load5");
    step(4'b0000, 4'b0000, 1'b0, 1'b1, 32'h0, 4'b0000, 4'b0000, 4'b0000, "F_apply5");
    step(4'b0001, 4'b0000, 1'b0, 1'b1, 32'h0, 4'b0001, 4'b0001, 4'b0000, "F_cnt0");
    step(4'b0001, 4'b0000, 1'b0, 1'b1, 32'h0, 4'b0001, 4'b0000, 4'b0000, "F_cnt1");
    step(4'b0001, 4'b0000, 1'b0, 1'b1, 32'h0, 4'b0001, 4'b0000, 4'b0000, "F_cnt2");
    step(4'b0001, 4'b0000, 1'b0, 1'b0, 32'h0, 4'b0000, 4'b0000, 4'b0000, "F_reset");
    step(4'b0001, 4'b0000, 1'b0, 1'b1, 32'h0, 4'b0001, 4'b0001, 4'b0000, "F_rel0");
    step(4'b0001, 4'b0000, 1'b0, 1'b1, 32'h0, 4'b0000, 4'b0000, 4'b0000, "F_rel1");
    step(4'b0001, 4'b0000, 1'b0, 1'b1, 32'h0, 4'b0001, 4'b0001, 4'b0000, "F_rel2");

    // drain
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_clk_div_bank
`default_nettype wire

// File: doc/clk_div_bank.md
CLK_DIV_BANK -- requirements
Module: clk_div_bank

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent divider channels (1..16).
REQ-002 Parameter DIV_W, default 8, divisor width in bits.
REQ-003 Parameter RST_DIV, default 2, active divisor loaded into every channel at reset.
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 rst_n  in  1  synchronous, active-low reset.
REQ-006 en_i  in  NUM_CH  per-channel run enable.
REQ-007 div_i  in  NUM_CH*DIV_W  per-channel new divisor (channel k at bits k*DIV_W +: DIV_W).
REQ-008 load_i  in  NUM_CH  per-channel strobe capturing div_i slice into a pending register.
REQ-009 sync_i  in  1  pulse restarting all enabled channels in phase.
REQ-010 wave_o  out  NUM_CH  registered divided square wave.
REQ-011 tick_o  out  NUM_CH  registered one-cycle pulse at period start.
REQ-012 pend_o  out  NUM_CH  high while a loaded divisor is not yet active.

Function
REQ-013 Each channel SHALL hold an active divisor N, a pending divisor P, and a counter cnt (DIV_W bits).
REQ-014 Running means en_i=1 and N>=1; when running, cnt SHALL step 0,1,...,N-1,0 with one step per clk.
REQ-015 wave_o SHALL be 1 when cnt < ceil(N/2), else 0: 50% duty for even N, high-biased by one cycle for odd N.
REQ-016 tick_o SHALL be 1 exactly in cycles where cnt==0 while running.
REQ-017 wave_o and tick_o SHALL be flops updated with cnt, never combinational decode.
REQ-018 N=1: tick_o SHALL be constantly 1 and wave_o constantly 1 while running.
REQ-019 N=0: channel SHALL be stopped, with cnt=0 and wave_o=tick_o=0.
REQ-020 load_i[k] SHALL capture P and set pend_o[k] the next cycle.
REQ-021 A second load before application SHALL overwrite P; last value wins.
REQ-022 Pending apply while running: P becomes N on the wrap edge (cnt N-1 -> 0), and pend_o clears that same edge, so no truncated or stretched period occurs.
REQ-023 Pending apply while stopped or disabled: P becomes N on the next edge.
REQ-024 en_i low: next cycle cnt=0 and wave_o=tick_o=0.
REQ-025 en_i rising: the first enabled cycle SHALL present cnt=0 with tick_o=1 and wave_o=1 (if N>=1).
REQ-026 sync_i: on the next edge, every running channel SHALL force cnt=0, apply any pending P, and assert tick_o.
REQ-027 sync_i SHALL leave disabled channels unaffected.
REQ-028 Simultaneous load_i and sync_i: the newly captured value SHALL be applied by the sync.
REQ-029 Simultaneous load_i and wrap edge: the new value SHALL wait for the following wrap.

Reset
REQ-030 rst_n low at a clk edge SHALL set N=RST_DIV, P=RST_DIV, cnt=0, and wave_o=tick_o=pend_o=0, aborting any period mid-count.
REQ-031 First cycle after rst_n release with en_i=1: behaves per REQ-025.

Structure
REQ-032 Package clk_div_pkg SHALL hold the NUM_CH/DIV_W/RST_DIV defaults and the max-channel constant.
REQ-033 Sub-module clk_div_chan (one channel) SHALL be instantiated NUM_CH times via generate; the top does only slicing and sync fan-out.

Verification
REQ-034 N=2, en=1 -> wave_o 1,0,1,0...; tick_o every 2nd cycle.
REQ-035 N=3 -> wave_o 1,1,0 repeating; N=16 -> 8 high/8 low with tick period 16.
REQ-036 Running N=4, load 6 at cnt=1 -> pend_o=1, remaining 4-period completes intact, next period is 6, pend_o clears at that wrap.
REQ-037 ch0 N=4, ch1 N=6 out of phase, sync_i pulse -> both tick_o high the same cycle, then ticks coincide every 12 cycles.
REQ-038 N=0 and N=1 -> stopped zeros; then constant-high wave and tick.
REQ-039 rst_n low mid-period with N=5 -> all outputs 0 next cycle, N restored to RST_DIV=2.
